wshbn_intercon: RTL and testbench

- Parametrised single-master, N-slave Wishbone interconnect. It replaces the hand-written decode, STB gating and DRD mux in the riscv_wishbone top level.
- Sits between wshbn_master and the peripheral slaves (pio, timer, UART, SPI, ...).
- Adds:
  - registered slave selection;
  - ACK/ERR routing from the selected slave only;
  - error response for unmapped addresses;
  - a bus-timeout watchdog, so a missing slave ACK can no longer hang the CPU.

---
 rtl/wshbn_ic_pkg.sv | 17 +
 rtl/wshbn_intercon_if.sv | 46 ++++
 rtl/wshbn_wdt.sv | 39 +++
 rtl/wshbn_intercon.sv | 149 ++++++++++++++
 tb/tb_wshbn_intercon.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wshbn_ic_pkg.sv
// Shared types and constants for the single-master Wishbone interconnect.
// Imported by the interconnect top level.
package wshbn_ic_pkg;

    // Width of the slave-select field taken from the master address.
    localparam int unsigned SelW = 4;

    // Largest slave count the select field can address.
    localparam int unsigned MaxSlv = 16;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StResp
    } ic_state_e;

endpackage

// File: rtl/wshbn_intercon_if.sv
// Bus bundle between one Wishbone master, the interconnect and N slaves.
// Signal names are seen from the interconnect (_I into it, _O out of it).
interface wshbn_intercon_if #(
    parameter int unsigned N_SLV = 4,
    parameter int unsigned ADR_W = 8,
    parameter int unsigned DAT_W = 32
);

    // Master side
    logic [ADR_W-1:0]       M_ADR_I;
    logic [DAT_W-1:0]       M_DAT_I;
    logic                   M_WE_I;
    logic                   M_STB_I;
    logic                   M_CYC_I;
    logic [DAT_W-1:0]       M_DAT_O;
    logic                   M_ACK_O;
    logic                   M_ERR_O;

    // Slave side
    logic [ADR_W-1:0]       S_ADR_O;
    logic [DAT_W-1:0]       S_DAT_O;
    logic                   S_WE_O;
    logic [N_SLV-1:0]       S_CYC_O;
    logic [N_SLV-1:0]       S_STB_O;
    logic [N_SLV*DAT_W-1:0] S_DAT_I;
    logic [N_SLV-1:0]       S_ACK_I;
    logic [N_SLV-1:0]       S_ERR_I;

    modport intercon (
        input  M_ADR_I, M_DAT_I, M_WE_I, M_STB_I, M_CYC_I,
        output M_DAT_O, M_ACK_O, M_ERR_O,
        output S_ADR_O, S_DAT_O, S_WE_O, S_CYC_O, S_STB_O,
        input  S_DAT_I, S_ACK_I, S_ERR_I
    );

    modport master (
        output M_ADR_I, M_DAT_I, M_WE_I, M_STB_I, M_CYC_I,
        input  M_DAT_O, M_ACK_O, M_ERR_O
    );

    modport slave (
        input  S_ADR_O, S_DAT_O, S_WE_O, S_CYC_O, S_STB_O,
        output S_DAT_I, S_ACK_I, S_ERR_I
    );

endinterface

// File: rtl/wshbn_wdt.sv
// Bus-timeout watchdog: counts enabled cycles and pulses expire_o on the
// TIMEOUT-th one. TIMEOUT of 0 disables it.
module wshbn_wdt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          Enabled = (TIMEOUT != 0);
    localparam logic [CntW-1:0] Last = Enabled ? CntW'(TIMEOUT - 1) : '0;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Holds at Last so a late clear can never see a wrapped count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != Last)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = Enabled && enable_i && (cnt_q == Last);

endmodule

// File: rtl/wshbn_intercon.sv
// Single-master, N-slave Wishbone interconnect with registered slave select,
// unmapped-address error, per-slave response routing and a bus watchdog.
module wshbn_intercon
    import wshbn_ic_pkg::*;
#(
    parameter int unsigned N_SLV   = 4,
    parameter int unsigned ADR_W   = 8,
    parameter int unsigned DAT_W   = 32,
    parameter int unsigned SEL_LO  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    wshbn_intercon_if.intercon  bus,
    output logic [7:0]          tmo_cnt_o,
    output logic [ADR_W-1:0]    err_adr_o
);

    ic_state_e        state_q, state_d;
    logic [SelW-1:0]  sel_q, sel_d;
    logic             err_q, err_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic [ADR_W-1:0] err_adr_q, err_adr_d;

    logic [SelW-1:0]  adr_sel;
    logic             sel_ok;
    logic             active;
    logic             slv_ack;
    logic             slv_err;
    logic [DAT_W-1:0] slv_dat;
    logic             wdt_expire;
    logic [N_SLV-1:0] stb;

    assign bus.S_ADR_O = bus.M_ADR_I;
    assign bus.S_DAT_O = bus.M_DAT_I;
    assign bus.S_WE_O  = bus.M_WE_I;

    assign adr_sel = bus.M_ADR_I[SEL_LO +: SelW];
    assign sel_ok  = (32'(adr_sel) < N_SLV);
    assign active  = (state_q == StActive);

    // Only the registered selection is looked at; other slaves are ignored.
    always_comb begin
        slv_ack = 1'b0;
        slv_err = 1'b0;
        slv_dat = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (sel_q == SelW'(k)) begin
                slv_ack = bus.S_ACK_I[k];
                slv_err = bus.S_ERR_I[k];
                slv_dat = bus.S_DAT_I[k*DAT_W +: DAT_W];
            end
        end
    end

    wshbn_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk_i    (CLK_I),
        .rst_ni   (RST_I),
        .clear_i  (!active),
        .enable_i (active),
        .expire_o (wdt_expire)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            tmo_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        err_d     = err_q;
        dat_d     = dat_q;
        tmo_cnt_d = tmo_cnt_q;
        err_adr_d = err_adr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.M_CYC_I && bus.M_STB_I) begin
                    sel_d = adr_sel;
                    if (sel_ok) begin
                        state_d = StActive;
                    end else begin
                        err_d     = 1'b1;
                        err_adr_d = bus.M_ADR_I;
                        state_d   = StResp;
                    end
                end
            end
            StActive: begin
                // Abort first: the master is no longer waiting for anything.
                if (!bus.M_CYC_I) begin
                    state_d = StIdle;
                end else if (slv_err) begin
                    err_d     = 1'b1;
                    err_adr_d = bus.M_ADR_I;
                    state_d   = StResp;
                end else if (slv_ack) begin
                    err_d = 1'b0;
                    if (!bus.M_WE_I) begin
                        dat_d = slv_dat;
                    end
                    state_d = StResp;
                end else if (wdt_expire) begin
                    err_d     = 1'b1;
                    err_adr_d = bus.M_ADR_I;
                    tmo_cnt_d = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        stb = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            stb[k] = active && (sel_q == SelW'(k));
        end
        bus.S_CYC_O = stb;
        bus.S_STB_O = stb;
        bus.M_ACK_O = (state_q == StResp) && !err_q;
        bus.M_ERR_O = (state_q == StResp) && err_q;
        bus.M_DAT_O = dat_q;
        tmo_cnt_o   = tmo_cnt_q;
        err_adr_o   = err_adr_q;
    end

endmodule

// File: tb/tb_wshbn_intercon.sv
// Scoreboard bench for wshbn_intercon: directed transfers push expected
// responses, a monitor pops and compares each ACK/ERR pulse.
module tb_wshbn_intercon;

    localparam int unsigned NS = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] tmo_cnt;
    logic [7:0] err_adr;

    wshbn_intercon_if #(.N_SLV(NS), .ADR_W(8), .DAT_W(32)) bus ();

    wshbn_intercon #(
        .N_SLV   (NS),
        .ADR_W   (8),
        .DAT_W   (32),
        .SEL_LO  (4),
        .TIMEOUT (8)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst_n),
        .bus       (bus),
        .tmo_cnt_o (tmo_cnt),
        .err_adr_o (err_adr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        logic [7:0]  tmo;
        logic [7:0]  eadr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Slave models: ack/err after ack_wait strobe cycles; noise drives ack/err
    // regardless of strobe to prove non-selected slaves are ignored.
    logic [31:0] rdata    [NS];
    bit          ack_en   [NS];
    bit          err_en   [NS];
    bit          noise    [NS];
    int          ack_wait [NS];
    int          stb_cnt  [NS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) stb_cnt[k] <= 0;
        end else begin
            for (int k = 0; k < NS; k++) stb_cnt[k] <= bus.S_STB_O[k] ? stb_cnt[k] + 1 : 0;
        end
    end

    always_comb begin
        bus.S_ACK_I = '0;
        bus.S_ERR_I = '0;
        bus.S_DAT_I = '0;
        for (int k = 0; k < NS; k++) begin
            bus.S_ACK_I[k] = noise[k] ||
                (bus.S_STB_O[k] && ack_en[k] && (stb_cnt[k] == ack_wait[k]));
            bus.S_ERR_I[k] = noise[k] ||
                (bus.S_STB_O[k] && err_en[k] && (stb_cnt[k] == ack_wait[k]));
            bus.S_DAT_I[k*32 +: 32] = rdata[k];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every ACK/ERR cycle must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.M_ACK_O || bus.M_ERR_O) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", {bus.M_ACK_O, bus.M_ERR_O}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_ack", bus.M_ACK_O, !e.err);
                    chk("sb_err", bus.M_ERR_O, e.err);
                    chk("sb_dat", bus.M_DAT_O, e.dat);
                    chk("sb_tmo_cnt", tmo_cnt, e.tmo);
                    chk("sb_err_adr", err_adr, e.eadr);
                end
            end
        end
    end

    task automatic xfer(input logic [7:0] adr, input logic [31:0] dat, input logic we,
                        output int lat, output logic [3:0] stb_or, output int stb_cyc,
                        output bit bc_ok);
        bit done;
        done    = 1'b0;
        lat     = -1;
        stb_or  = '0;
        stb_cyc = 0;
        bc_ok   = 1'b1;
        @(posedge clk); #1;
        bus.M_ADR_I = adr;
        bus.M_DAT_I = dat;
        bus.M_WE_I  = we;
        bus.M_CYC_I = 1'b1;
        bus.M_STB_I = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.S_STB_O != '0) stb_cyc++;
            stb_or |= bus.S_STB_O;
            if (bus.S_STB_O !== bus.S_CYC_O || $countones(bus.S_STB_O) > 1 ||
                bus.S_ADR_O !== adr || bus.S_DAT_O !== dat || bus.S_WE_O !== we) bc_ok = 1'b0;
            if (bus.M_ACK_O || bus.M_ERR_O) begin
                lat  = i;
                done = 1'b1;
            end
        end
        if (!done) chk("resp_bound", 0, 1);
        @(posedge clk); #1;
        bus.M_CYC_I = 1'b0;
        bus.M_STB_I = 1'b0;
        bus.M_WE_I  = 1'b0;
    endtask

    initial begin
        int          lat;
        int          sc;
        logic [3:0]  so;
        bit          bc;
        bit          seen;
        bus.M_ADR_I = '0;
        bus.M_DAT_I = '0;
        bus.M_WE_I  = 1'b0;
        bus.M_STB_I = 1'b0;
        bus.M_CYC_I = 1'b0;
        for (int k = 0; k < NS; k++) begin
            rdata[k]    = 32'h0;
            ack_en[k]   = 1'b1;
            err_en[k]   = 1'b0;
            noise[k]    = 1'b0;
            ack_wait[k] = 0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ack", bus.M_ACK_O, 0);
        chk("rst_err", bus.M_ERR_O, 0);
        chk("rst_dat", bus.M_DAT_O, 0);
        chk("rst_cyc_stb", {bus.S_CYC_O, bus.S_STB_O}, 0);
        chk("rst_tmo_cnt", tmo_cnt, 0);
        chk("rst_err_adr", err_adr, 0);

        // Read slave 1, acked in its first strobe cycle
        rdata[1] = 32'hDEADBEEF;
        exp_q.push_back('{1'b0, 32'hDEADBEEF, 8'd0, 8'h00});
        xfer(8'h14, 32'h0, 1'b0, lat, so, sc, bc);
        chk("rd1_latency", lat, 2);
        chk("rd1_stb", so, 4'b0010);
        chk("rd1_stb_cycles", sc, 1);
        chk("rd1_bcast", bc, 1);

        // Write slave 0 after 3 wait cycles; read data must not be captured
        rdata[0]    = 32'h12345678;
        ack_wait[0] = 3;
        exp_q.push_back('{1'b0, 32'hDEADBEEF, 8'd0, 8'h00});
        xfer(8'h02, 32'h0000A5A5, 1'b1, lat, so, sc, bc);
        chk("wr0_latency", lat, 5);
        chk("wr0_stb", so, 4'b0001);
        chk("wr0_stb_cycles", sc, 4);
        chk("wr0_bcast", bc, 1);

        // Unmapped address
        exp_q.push_back('{1'b1, 32'hDEADBEEF, 8'd0, 8'h50});
        xfer(8'h50, 32'h0, 1'b0, lat, so, sc, bc);
        chk("unmap_latency", lat, 1);
        chk("unmap_stb", so, 4'b0000);

        // Timeout on slave 2 while the other slaves assert ack/err noise
        ack_en[2] = 1'b0;
        noise[0]  = 1'b1;
        noise[1]  = 1'b1;
        noise[3]  = 1'b1;
        exp_q.push_back('{1'b1, 32'hDEADBEEF, 8'd1, 8'h20});
        xfer(8'h20, 32'h0, 1'b0, lat, so, sc, bc);
        chk("tmo_latency", lat, 9);
        chk("tmo_stb", so, 4'b0100);
        chk("tmo_stb_cycles", sc, 8);
        for (int k = 0; k < NS; k++) noise[k] = 1'b0;

        // Simultaneous ack and err from slave 3: err wins
        rdata[3]  = 32'h11112222;
        err_en[3] = 1'b1;
        exp_q.push_back('{1'b1, 32'hDEADBEEF, 8'd1, 8'h3C});
        xfer(8'h3C, 32'h0, 1'b0, lat, so, sc, bc);
        chk("ackerr_latency", lat, 2);
        err_en[3] = 1'b0;

        // Ack in the watchdog expire cycle: ack wins, count unchanged
        rdata[2]    = 32'hCAFEF00D;
        ack_en[2]   = 1'b1;
        ack_wait[2] = 7;
        exp_q.push_back('{1'b0, 32'hCAFEF00D, 8'd1, 8'h3C});
        xfer(8'h24, 32'h0, 1'b0, lat, so, sc, bc);
        chk("ackexp_latency", lat, 9);
        chk("ackexp_stb_cycles", sc, 8);
        ack_en[2]   = 1'b0;
        ack_wait[2] = 0;

        // Master abort mid-ACTIVE
        @(posedge clk); #1;
        bus.M_ADR_I = 8'h20;
        bus.M_CYC_I = 1'b1;
        bus.M_STB_I = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_pre_stb", bus.S_STB_O, 4'b0100);
        @(posedge clk); #1;
        bus.M_CYC_I = 1'b0;
        bus.M_STB_I = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_stb_low", {bus.S_CYC_O, bus.S_STB_O}, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.M_ACK_O || bus.M_ERR_O) seen = 1'b1;
        end
        chk("abort_no_resp", seen, 0);

        // Asynchronous reset mid-ACTIVE
        @(posedge clk); #1;
        bus.M_ADR_I = 8'h20;
        bus.M_CYC_I = 1'b1;
        bus.M_STB_I = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_pre_stb", bus.S_STB_O, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc_stb", {bus.S_CYC_O, bus.S_STB_O}, 0);
        chk("arst_ack_err", {bus.M_ACK_O, bus.M_ERR_O}, 0);
        chk("arst_dat", bus.M_DAT_O, 0);
        chk("arst_tmo_cnt", tmo_cnt, 0);
        chk("arst_err_adr", err_adr, 0);
        bus.M_CYC_I = 1'b0;
        bus.M_STB_I = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        exp_q.push_back('{1'b0, 32'hDEADBEEF, 8'd0, 8'h00});
        xfer(8'h14, 32'h0, 1'b0, lat, so, sc, bc);
        chk("post_rst_latency", lat, 2);

        // Repeated timeouts saturate the counter at 255
        for (int i = 1; i <= 300; i++) begin
            exp_q.push_back('{1'b1, 32'hDEADBEEF, (i > 255) ? 8'd255 : 8'(i), 8'h20});
            xfer(8'h20, 32'h0, 1'b0, lat, so, sc, bc);
        end
        chk("tmo_saturated", tmo_cnt, 8'd255);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
